// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_ctrl_pkg
// Brief    : State encoding, decode-bus bit indices and output codes for core_ctrl
// Revision : 1.0
// ============================================================================
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_WAIT_I   = 4'd2,
        S_DECODE   = 4'd3,
        S_EXEC     = 4'd4,
        S_MEM_REQ  = 4'd5,
        S_MEM_WAIT = 4'd6,
        S_WB       = 4'd7,
        S_EXC      = 4'd8,
        S_HALT     = 4'd9
    } state_e;

    // opinfo_i one-hot class bits
    localparam int C_OP_ALU    = 0;
    localparam int C_OP_ALUI   = 1;
    localparam int C_OP_ALUW   = 2;
    localparam int C_OP_ALUIW  = 3;
    localparam int C_OP_BRANCH = 4;
    localparam int C_OP_JAL    = 5;
    localparam int C_OP_JALR   = 6;
    localparam int C_OP_LOAD   = 7;
    localparam int C_OP_STORE  = 8;
    localparam int C_OP_LUI    = 9;
    localparam int C_OP_AUIPC  = 10;
    localparam int C_OP_SYS    = 11;

    // load_i / store_i / sys_i bits
    localparam int C_LD_LH  = 1;
    localparam int C_LD_LW  = 2;
    localparam int C_LD_LD  = 3;
    localparam int C_LD_LBU = 4;
    localparam int C_LD_LHU = 5;
    localparam int C_LD_LWU = 6;
    localparam int C_ST_SH  = 1;
    localparam int C_ST_SW  = 2;
    localparam int C_ST_SD  = 3;
    localparam int C_SYS_ECALL  = 0;
    localparam int C_SYS_EBREAK = 1;

    localparam logic [1:0] C_PC_SEQ  = 2'd0;
    localparam logic [1:0] C_PC_BR   = 2'd1;
    localparam logic [1:0] C_PC_JMP  = 2'd2;
    localparam logic [1:0] C_PC_TRAP = 2'd3;

    localparam logic [1:0] C_EXC_ILLEGAL = 2'd0;
    localparam logic [1:0] C_EXC_ECALL   = 2'd1;
    localparam logic [1:0] C_EXC_IFU     = 2'd2;
    localparam logic [1:0] C_EXC_LSU     = 2'd3;

    function automatic logic is_onehot(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_ctrl_wdog.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_wdog
// Brief    : Bus-response watchdog; expires in the (2**TMO_W-1)-th enabled cycle
// Revision : 1.0
// ============================================================================
module ctrl_wdog #(
    parameter int TMO_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Count holds (cycles waited - 1), so this value marks the last allowed cycle.
    localparam logic [TMO_W-1:0] C_LAST = TMO_W'((2 ** TMO_W) - 2);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    assign expired = en && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_ctrl
// Brief    : Multi-cycle fetch/decode/exec/mem/writeback control FSM of the NPC core
// Revision : 1.0
// ============================================================================
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int TMO_W = 8,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    input  logic             ifu_rsp_valid,
    input  logic             ifu_rsp_err,
    output logic             inst_we,
    input  logic [11:0]      opinfo_i,
    input  logic [6:0]       load_i,
    input  logic [3:0]       store_i,
    input  logic [1:0]       sys_i,
    input  logic             branch_taken_i,
    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    output logic             lsu_req_wen,
    output logic [1:0]       lsu_req_size,
    output logic             lsu_req_uns,
    input  logic             lsu_rsp_valid,
    input  logic             lsu_rsp_err,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             exc_valid,
    output logic [1:0]       exc_cause,
    output logic             halt_o,
    output logic [CNT_W-1:0] mcycle_o,
    output logic [CNT_W-1:0] minstret_o
);

    state_e     r_state;
    state_e     w_next;
    logic       w_exc_set;
    logic [1:0] w_exc_code;
    logic [1:0] r_cause;
    logic [1:0] r_pc_sel;
    logic       r_rf_wr;
    logic       r_is_mem;
    logic       r_is_br;
    logic       r_is_jmp;
    logic       r_wen;
    logic [1:0] r_size;
    logic       r_uns;

    logic       w_illegal;
    logic       w_rf_wr;
    logic [1:0] w_size;
    logic       w_uns;
    logic       w_wait;
    logic       w_tmo;

    assign w_wait = (r_state == S_WAIT_I) || (r_state == S_MEM_WAIT);

    // Held in clear outside the wait states, so every wait starts from zero.
    ctrl_wdog #(
        .TMO_W  (TMO_W)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!w_wait),
        .en      (w_wait),
        .expired (w_tmo)
    );

    assign w_illegal = !is_onehot(16'(opinfo_i))
                    || (opinfo_i[C_OP_LOAD]  && !is_onehot(16'(load_i)))
                    || (opinfo_i[C_OP_STORE] && !is_onehot(16'(store_i)))
                    || (opinfo_i[C_OP_SYS]   && !is_onehot(16'(sys_i)));

    assign w_rf_wr = opinfo_i[C_OP_ALU]  | opinfo_i[C_OP_ALUI]  | opinfo_i[C_OP_ALUW]
                   | opinfo_i[C_OP_ALUIW] | opinfo_i[C_OP_JAL]  | opinfo_i[C_OP_JALR]
                   | opinfo_i[C_OP_LUI]  | opinfo_i[C_OP_AUIPC] | opinfo_i[C_OP_LOAD];

    always_comb begin
        w_size = 2'd0;
        w_uns  = 1'b0;
        if (opinfo_i[C_OP_STORE]) begin
            w_size[0] = store_i[C_ST_SH] | store_i[C_ST_SD];
            w_size[1] = store_i[C_ST_SW] | store_i[C_ST_SD];
        end else begin
            w_size[0] = load_i[C_LD_LH] | load_i[C_LD_LHU] | load_i[C_LD_LD];
            w_size[1] = load_i[C_LD_LW] | load_i[C_LD_LWU] | load_i[C_LD_LD];
            w_uns     = load_i[C_LD_LBU] | load_i[C_LD_LHU] | load_i[C_LD_LWU];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_exc_set     = 1'b0;
        w_exc_code    = C_EXC_ILLEGAL;
        ifu_req_valid = 1'b0;
        inst_we       = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_req_wen   = 1'b0;
        lsu_req_size  = 2'd0;
        lsu_req_uns   = 1'b0;
        rf_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = C_PC_SEQ;
        exc_valid     = 1'b0;
        exc_cause     = 2'd0;
        halt_o        = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                ifu_req_valid = 1'b1;
                if (ifu_req_ready) w_next = S_WAIT_I;
            end
            S_WAIT_I: begin
                // A response arriving in the timeout cycle wins over the watchdog.
                if (ifu_rsp_valid) begin
                    if (ifu_rsp_err) begin
                        w_exc_set  = 1'b1;
                        w_exc_code = C_EXC_IFU;
                        w_next     = S_EXC;
                    end else begin
                        inst_we = 1'b1;
                        w_next  = S_DECODE;
                    end
                end else if (w_tmo) begin
                    w_exc_set  = 1'b1;
                    w_exc_code = C_EXC_IFU;
                    w_next     = S_EXC;
                end
            end
            S_DECODE: begin
                if (w_illegal) begin
                    w_exc_set  = 1'b1;
                    w_exc_code = C_EXC_ILLEGAL;
                    w_next     = S_EXC;
                end else if (opinfo_i[C_OP_SYS] && sys_i[C_SYS_EBREAK]) begin
                    w_next = S_HALT;
                end else if (opinfo_i[C_OP_SYS] && sys_i[C_SYS_ECALL]) begin
                    w_exc_set  = 1'b1;
                    w_exc_code = C_EXC_ECALL;
                    w_next     = S_EXC;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: w_next = r_is_mem ? S_MEM_REQ : S_WB;
            S_MEM_REQ: begin
                lsu_req_valid = 1'b1;
                lsu_req_wen   = r_wen;
                lsu_req_size  = r_size;
                lsu_req_uns   = r_uns;
                if (lsu_req_ready) w_next = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (lsu_rsp_valid) begin
                    if (lsu_rsp_err) begin
                        w_exc_set  = 1'b1;
                        w_exc_code = C_EXC_LSU;
                        w_next     = S_EXC;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_tmo) begin
                    w_exc_set  = 1'b1;
                    w_exc_code = C_EXC_LSU;
                    w_next     = S_EXC;
                end
            end
            S_WB: begin
                rf_we  = r_rf_wr;
                pc_we  = 1'b1;
                pc_sel = r_pc_sel;
                w_next = S_FETCH;
            end
            S_EXC: begin
                pc_we     = 1'b1;
                pc_sel    = C_PC_TRAP;
                exc_valid = 1'b1;
                exc_cause = r_cause;
                w_next    = S_FETCH;
            end
            S_HALT: halt_o = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cause  <= 2'd0;
            r_pc_sel <= C_PC_SEQ;
            r_rf_wr  <= 1'b0;
            r_is_mem <= 1'b0;
            r_is_br  <= 1'b0;
            r_is_jmp <= 1'b0;
            r_wen    <= 1'b0;
            r_size   <= 2'd0;
            r_uns    <= 1'b0;
        end else begin
            if (w_exc_set) r_cause <= w_exc_code;
            if (r_state == S_DECODE) begin
                r_rf_wr  <= w_rf_wr;
                r_is_mem <= opinfo_i[C_OP_LOAD] | opinfo_i[C_OP_STORE];
                r_is_br  <= opinfo_i[C_OP_BRANCH];
                r_is_jmp <= opinfo_i[C_OP_JAL] | opinfo_i[C_OP_JALR];
                r_wen    <= opinfo_i[C_OP_STORE];
                r_size   <= w_size;
                r_uns    <= w_uns & opinfo_i[C_OP_LOAD];
            end
            if (r_state == S_EXEC) begin
                if (r_is_br && branch_taken_i) r_pc_sel <= C_PC_BR;
                else if (r_is_jmp)             r_pc_sel <= C_PC_JMP;
                else                           r_pc_sel <= C_PC_SEQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcycle_o   <= '0;
            minstret_o <= '0;
        end else begin
            if (r_state != S_HALT) mcycle_o   <= mcycle_o + CNT_W'(1);
            if (r_state == S_WB)   minstret_o <= minstret_o + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_ctrl
// Brief    : Directed self-checking bench for core_ctrl
// Revision : 1.0
// ============================================================================
module tb_core_ctrl;

    localparam int TMO_W = 4;
    localparam int CNT_W = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, inst_we;
    logic [11:0]      opinfo;
    logic [6:0]       load;
    logic [3:0]       store;
    logic [1:0]       sys;
    logic             branch_taken;
    logic             lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_req_uns;
    logic [1:0]       lsu_req_size;
    logic             lsu_rsp_valid, lsu_rsp_err;
    logic             rf_we, pc_we, exc_valid, halt_o;
    logic [1:0]       pc_sel, exc_cause;
    logic [CNT_W-1:0] mcycle, minstret;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    core_ctrl #(
        .TMO_W (TMO_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_rsp_valid  (ifu_rsp_valid),
        .ifu_rsp_err    (ifu_rsp_err),
        .inst_we        (inst_we),
        .opinfo_i       (opinfo),
        .load_i         (load),
        .store_i        (store),
        .sys_i          (sys),
        .branch_taken_i (branch_taken),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_size   (lsu_req_size),
        .lsu_req_uns    (lsu_req_uns),
        .lsu_rsp_valid  (lsu_rsp_valid),
        .lsu_rsp_err    (lsu_rsp_err),
        .rf_we          (rf_we),
        .pc_we          (pc_we),
        .pc_sel         (pc_sel),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .halt_o         (halt_o),
        .mcycle_o       (mcycle),
        .minstret_o     (minstret)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic set_op(input logic [11:0] op, input logic [6:0] ld, input logic [3:0] st,
                          input logic [1:0] sy, input logic bt);
        opinfo = op; load = ld; store = st; sys = sy; branch_taken = bt;
    endtask

    // Runs one instruction starting from FETCH until the pc_we pulse; cycle 1 = FETCH.
    task automatic run_inst(input int ifu_dly, input int lsu_dly, input logic lsu_e,
                            input logic [1:0] exp_size, input logic exp_wen, input logic exp_uns,
                            output int n_cyc, output int iwe_cyc, output logic rfw,
                            output logic [1:0] sel, output logic exc, output logic [1:0] cause,
                            output logic [63:0] mc);
        int   wcnt = 0;
        int   nreq = 0;
        logic waiting = 1'b0;
        logic mwait = 1'b0;
        logic done = 1'b0;
        n_cyc = 0; iwe_cyc = 0; rfw = 1'b0; sel = 2'd0; exc = 1'b0; cause = 2'd0; mc = '0;
        while (!done && n_cyc < 60) begin
            @(negedge clk);
            n_cyc++;
            if (waiting) wcnt++;
            ifu_rsp_valid = waiting && (wcnt > ifu_dly);
            lsu_rsp_valid = mwait;
            lsu_rsp_err   = mwait && lsu_e;
            #1;
            if (inst_we) begin
                iwe_cyc = n_cyc;
                waiting = 1'b0;
            end
            if (ifu_req_valid) waiting = 1'b1;
            if (mwait) mwait = 1'b0;
            if (lsu_req_valid) begin
                nreq++;
                chk("lsu_wen", lsu_req_wen, exp_wen);
                chk("lsu_size", lsu_req_size, exp_size);
                chk("lsu_uns", lsu_req_uns, exp_uns);
                lsu_req_ready = (nreq > lsu_dly);
                if (lsu_req_ready) mwait = 1'b1;
            end else begin
                lsu_req_ready = 1'b0;
            end
            if (pc_we) begin
                done = 1'b1; waiting = 1'b0;
                rfw = rf_we; sel = pc_sel; exc = exc_valid; cause = exc_cause; mc = mcycle;
            end
        end
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rsp_err   = 1'b0;
        if (!done) chk("pc_we_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_minstret(input string tag, input logic [63:0] exp);
        @(posedge clk);
        #1;
        chk(tag, minstret, exp);
    endtask

    initial begin
        int         n, iw, hcyc;
        logic       rf, ex;
        logic [1:0] sel, ca;
        logic [63:0] mc;

        rst_n = 1'b0;
        ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0;
        lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; lsu_rsp_err = 1'b0;
        set_op(12'h000, 7'h00, 4'h0, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs", {ifu_req_valid, inst_we, lsu_req_valid, rf_we, pc_we, pc_sel,
                         exc_valid, exc_cause, halt_o}, 64'd0);
        chk("rst_mcycle", mcycle, 64'd0);
        chk("rst_minstret", minstret, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_req", ifu_req_valid, 64'd0);

        // addi
        set_op(12'h002, 7'h00, 4'h0, 2'b00, 1'b0);
        run_inst(0, 0, 1'b0, 2'd0, 1'b0, 1'b0, n, iw, rf, sel, ex, ca, mc);
        chk("addi_iwe_cyc", iw, 2);
        chk("addi_len", n, 5);
        chk("addi_rf", rf, 1);
        chk("addi_sel", sel, 0);
        chk("addi_exc", ex, 0);
        chk("addi_mcycle", mc, 5);
        chk_minstret("addi_minstret", 1);

        // ld, LSU ready after 3 wait cycles
        set_op(12'h080, 7'b0001000, 4'h0, 2'b00, 1'b0);
        run_inst(0, 3, 1'b0, 2'd3, 1'b0, 1'b0, n, iw, rf, sel, ex, ca, mc);
        chk("ld_len", n, 10);
        chk("ld_rf", rf, 1);
        chk("ld_sel", sel, 0);
        chk_minstret("ld_minstret", 2);

        // beq taken / not taken
        set_op(12'h010, 7'h00, 4'h0, 2'b00, 1'b1);
        run_inst(0, 0, 1'b0, 2'd0, 1'b0, 1'b0, n, iw, rf, sel, ex, ca, mc);
        chk("beqt_sel", sel, 1);
        chk("beqt_rf", rf, 0);
        chk_minstret("beqt_minstret", 3);
        set_op(12'h010, 7'h00, 4'h0, 2'b00, 1'b0);
        run_inst(0, 0, 1'b0, 2'd0, 1'b0, 1'b0, n, iw, rf, sel, ex, ca, mc);
        chk("beqn_sel", sel, 0);
        chk("beqn_rf", rf, 0);
        chk_minstret("beqn_minstret", 4);

        // jal
        set_op(12'h020, 7'h00, 4'h0, 2'b00, 1'b0);
        run_inst(0, 0, 1'b0, 2'd0, 1'b0, 1'b0, n, iw, rf, sel, ex, ca, mc);
        chk("jal_sel", sel, 2);
        chk("jal_rf", rf, 1);
        chk_minstret("jal_minstret", 5);

        // sw, 0-wait
        set_op(12'h100, 7'h00, 4'b0100, 2'b00, 1'b0);
        run_inst(0, 0, 1'b0, 2'd2, 1'b1, 1'b0, n, iw, rf, sel, ex, ca, mc);
        chk("sw_len", n, 7);
        chk("sw_rf", rf, 0);
        chk("sw_sel", sel, 0);
        chk_minstret("sw_minstret", 6);

        // lhu with LSU bus error
        set_op(12'h080, 7'b0100000, 4'h0, 2'b00, 1'b0);
        run_inst(0, 0, 1'b1, 2'd1, 1'b0, 1'b1, n, iw, rf, sel, ex, ca, mc);
        chk("lsuerr_len", n, 7);
        chk("lsuerr_exc", ex, 1);
        chk("lsuerr_cause", ca, 3);
        chk("lsuerr_sel", sel, 3);
        chk("lsuerr_rf", rf, 0);
        chk_minstret("lsuerr_minstret", 6);

        // illegal: two class bits
        set_op(12'h003, 7'h00, 4'h0, 2'b00, 1'b0);
        run_inst(0, 0, 1'b0, 2'd0, 1'b0, 1'b0, n, iw, rf, sel, ex, ca, mc);
        chk("ill_len", n, 4);
        chk("ill_exc", ex, 1);
        chk("ill_cause", ca, 0);
        chk("ill_sel", sel, 3);
        chk("ill_rf", rf, 0);
        chk_minstret("ill_minstret", 6);

        // ecall
        set_op(12'h800, 7'h00, 4'h0, 2'b01, 1'b0);
        run_inst(0, 0, 1'b0, 2'd0, 1'b0, 1'b0, n, iw, rf, sel, ex, ca, mc);
        chk("ecall_exc", ex, 1);
        chk("ecall_cause", ca, 1);
        chk_minstret("ecall_minstret", 6);

        // fetch watchdog: no response at all, then response in the timeout cycle
        set_op(12'h001, 7'h00, 4'h0, 2'b00, 1'b0);
        run_inst(1000, 0, 1'b0, 2'd0, 1'b0, 1'b0, n, iw, rf, sel, ex, ca, mc);
        chk("tmo_len", n, 2 + (2 ** TMO_W - 1));
        chk("tmo_iwe", iw, 0);
        chk("tmo_exc", ex, 1);
        chk("tmo_cause", ca, 2);
        chk_minstret("tmo_minstret", 6);
        run_inst(2 ** TMO_W - 2, 0, 1'b0, 2'd0, 1'b0, 1'b0, n, iw, rf, sel, ex, ca, mc);
        chk("tmo15_iwe", iw, 16);
        chk("tmo15_len", n, 19);
        chk("tmo15_exc", ex, 0);
        chk("tmo15_rf", rf, 1);
        chk_minstret("tmo15_minstret", 7);

        // reset while in MEM_WAIT, late LSU response afterwards
        set_op(12'h080, 7'b0000100, 4'h0, 2'b00, 1'b0);
        ifu_rsp_valid = 1'b1;
        lsu_req_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("abort_memreq", lsu_req_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_memwait_pc", pc_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ifu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b1;
        #1;
        chk("abort_idle_outs", {ifu_req_valid, lsu_req_valid, rf_we, pc_we, exc_valid, halt_o}, 0);
        chk("abort_mcycle", mcycle, 0);
        chk("abort_minstret", minstret, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("abort_fetch", {ifu_req_valid, lsu_req_valid, rf_we, pc_we}, 4'b1000);
        end
        lsu_rsp_valid = 1'b0;

        // ebreak from a fresh reset: halt, mcycle frozen
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ifu_req_ready = 1'b1;
        ifu_rsp_valid = 1'b1;
        set_op(12'h800, 7'h00, 4'h0, 2'b10, 1'b0);
        hcyc = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            #1;
            if (halt_o && hcyc == 0) begin
                hcyc = c;
                chk("halt_mcycle_entry", mcycle, 4);
            end
        end
        chk("halt_cycle", hcyc, 4);
        chk("halt_sticky", halt_o, 1);
        chk("halt_mcycle_frozen", mcycle, 4);
        chk("halt_minstret", minstret, 0);
        chk("halt_outs", {ifu_req_valid, inst_we, lsu_req_valid, rf_we, pc_we, exc_valid}, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
